fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the data word width.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port RST, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port RD, output, 1 bit: read strobe to the FIFO read side.
REQ-005 SHALL have port EMPTY, input, 1 bit: FIFO empty flag.
REQ-006 SHALL have port FIFO_DOUT, input, WIDTH bits: FIFO read data.
REQ-007 SHALL have port FIFO_VALID, input, 1 bit: FIFO_DOUT is valid this cycle.
REQ-008 SHALL have port UNDER, input, 1 bit: FIFO underflow flag.
REQ-009 SHALL have port OUT_DATA, output, WIDTH bits: downstream data.
REQ-010 SHALL have port OUT_VALID, output, 1 bit: OUT_DATA is valid.
REQ-011 SHALL have port OUT_READY, input, 1 bit: downstream accepts the word.
REQ-012 SHALL have port ERR, output, 1 bit: sticky protocol-error flag.

Function
REQ-013 SHALL hold a 2-entry in-order output buffer; OUT_DATA SHALL be the oldest entry and OUT_VALID SHALL be 1 exactly when occupancy > 0.
REQ-014 SHALL count one transfer on each cycle where OUT_VALID=1 and OUT_READY=1, and SHALL then pop the oldest entry.
REQ-015 SHALL treat the FIFO as fixed 1-cycle latency: a word requested by RD=1 in cycle N arrives with FIFO_VALID=1 in cycle N+1.
REQ-016 SHALL drive RD=1 combinationally only when EMPTY=0, ERR=0, and (occupancy + inflight − pop_this_cycle) < 2; inflight is a 1-bit register equal to the previous cycle's RD.
REQ-017 SHALL push FIFO_DOUT into the buffer on every cycle where FIFO_VALID=1 and inflight=1.
REQ-018 SHALL allow a push and a pop in the same cycle; occupancy is then unchanged and order is preserved.
REQ-019 SHALL run an FSM with states IDLE (occupancy 0, inflight 0), ACTIVE (occupancy 1 or inflight 1), FULL (occupancy 2), and ERROR.
REQ-020 SHALL take the transitions IDLE→ACTIVE on RD=1; ACTIVE→FULL when the buffer reaches 2; FULL→ACTIVE on a pop; ACTIVE→IDLE when the buffer drains with nothing inflight.
REQ-021 SHALL enter ERROR and set ERR=1 from any state on any of the following: FIFO_VALID=1 with inflight=0; inflight=1 with FIFO_VALID=0; or UNDER=1.
REQ-022 SHALL, in ERROR, hold RD=0 and still drain buffered words to OUT_DATA; ERROR SHALL be left only by reset.
REQ-023 SHALL NOT permit OUT_DATA to change while OUT_VALID=1 and OUT_READY=0.
REQ-024 SHALL sustain one word per cycle when EMPTY=0 and OUT_READY=1 continuously, with first-word latency of 2 cycles from RD.

Reset
REQ-025 SHALL, on RST=0, asynchronously clear occupancy, inflight, ERR, and the FSM (to IDLE); RD=0, OUT_VALID=0, OUT_DATA=0.
REQ-026 SHALL discard buffered and in-flight words on reset mid-operation; a FIFO_VALID in the first cycle after reset release SHALL set ERR.
REQ-027 SHALL release reset synchronously to CLK; the first RD is possible in the first cycle after release.

Configuration
REQ-028 SHALL, with macro FIFO_READER_CNT_EN defined, add output port WCNT (16 bits) counting completed downstream transfers, wrapping 16'hFFFF→16'h0000 and cleared by reset.
REQ-029 SHALL, without FIFO_READER_CNT_EN, have no WCNT port and no counter logic, with all other behaviour identical.

Verification
REQ-030 SHALL cover this scenario: reset held for 2 cycles, then released with EMPTY=1 → RD=0, OUT_VALID=0, ERR=0, state IDLE.
REQ-031 SHALL cover this scenario: FIFO preloaded with 16'h0001..16'h0008 and OUT_READY=1 → OUT_DATA shows 0001..0008 on 8 consecutive cycles starting 2 cycles after the first RD, then EMPTY=1 → RD=0.
REQ-032 SHALL cover this scenario: OUT_READY=0 with 5 words available → exactly 2 RD pulses, state FULL, OUT_DATA held at the first word; OUT_READY=1 resumes in order with no loss.
REQ-033 SHALL cover this scenario: OUT_READY toggled every cycle with 8 words → all 8 delivered in order with no duplicates.
REQ-034 SHALL cover this scenario: FIFO_VALID forced 1 with no preceding RD → ERR=1 next edge, RD stays 0, buffered words still drain; RST=0 clears ERR.
REQ-035 SHALL cover this scenario: with FIFO_READER_CNT_EN defined, 65537 transfers → WCNT=16'h0001.

Source files
------------

// File: rtl/fifo_reader.sv
// Pulls words from a 1-cycle-latency FIFO into a 2-entry output buffer feeding a valid/ready sink.
// Optional build macro FIFO_READER_CNT_EN adds the WCNT transfer counter port.
module fifo_reader #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST,
   output logic             RD,
   input  logic             EMPTY,
   input  logic [WIDTH-1:0] FIFO_DOUT,
   input  logic             FIFO_VALID,
   input  logic             UNDER,
   output logic [WIDTH-1:0] OUT_DATA,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [1:0]       o_dbg_state,
`ifdef FIFO_READER_CNT_EN
   output logic [15:0]      WCNT,
`endif
   output logic             ERR
);

   // Downstream handshake: a word transfers on every cycle where OUT_VALID and OUT_READY
   // are both high; OUT_DATA is held stable while OUT_VALID is high and OUT_READY is low.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_FULL   = 2'd2,
      S_ERROR  = 2'd3
   } state_t;

   state_t           r_state;
   logic [1:0]       r_occ;
   logic             r_inflight;
   logic             r_err;
   logic [WIDTH-1:0] r_buf0;
   logic [WIDTH-1:0] r_buf1;

   logic             w_pop;
   logic             w_push;
   logic             w_err_evt;
   logic [1:0]       w_occ_nxt;
   logic [2:0]       w_need;

   assign OUT_VALID   = (r_occ != 2'd0);
   assign OUT_DATA    = r_buf0;
   assign ERR         = r_err;
   assign o_dbg_state = r_state;

   assign w_pop     = OUT_VALID && OUT_READY;
   // The full-buffer guard only matters after a protocol error; normal RD gating never overfills.
   assign w_push    = FIFO_VALID && r_inflight && ((r_occ != 2'd2) || w_pop);
   assign w_need    = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_occ_nxt = r_occ + {1'b0, w_push} - {1'b0, w_pop};
   assign w_err_evt = (FIFO_VALID && !r_inflight) || (r_inflight && !FIFO_VALID) || UNDER;

   assign RD = RST && !EMPTY && !r_err && (w_need < 3'd2);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= S_IDLE;
         r_occ      <= 2'd0;
         r_inflight <= 1'b0;
         r_err      <= 1'b0;
         r_buf0     <= '0;
         r_buf1     <= '0;
      end else begin
         r_inflight <= RD;
         r_occ      <= w_occ_nxt;
         if (w_pop) begin
            r_buf0 <= (w_push && (r_occ == 2'd1)) ? FIFO_DOUT : r_buf1;
            if (w_push && (r_occ == 2'd2)) r_buf1 <= FIFO_DOUT;
         end else if (w_push) begin
            if (r_occ == 2'd0) r_buf0 <= FIFO_DOUT;
            else               r_buf1 <= FIFO_DOUT;
         end
         if (w_err_evt || (r_state == S_ERROR)) begin
            r_state <= S_ERROR;
            r_err   <= 1'b1;
         end else if (w_occ_nxt == 2'd2) begin
            r_state <= S_FULL;
         end else if ((w_occ_nxt != 2'd0) || RD) begin
            r_state <= S_ACTIVE;
         end else begin
            r_state <= S_IDLE;
         end
      end
   end

`ifdef FIFO_READER_CNT_EN
   logic [15:0] r_wcnt;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)       r_wcnt <= 16'h0000;
      else if (w_pop) r_wcnt <= r_wcnt + 16'h0001;
   end

   assign WCNT = r_wcnt;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural 1-cycle-latency FIFO on the read side.
// Define FIFO_READER_CNT_EN to also exercise the WCNT wrap scenario.
module tb_fifo_reader;
   localparam int W = 16;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         RD;
   logic         EMPTY = 1'b1;
   logic [W-1:0] FIFO_DOUT = '0;
   logic         FIFO_VALID = 1'b0;
   logic         UNDER = 1'b0;
   logic [W-1:0] OUT_DATA;
   logic         OUT_VALID;
   logic         OUT_READY = 1'b0;
   logic [1:0]   o_dbg_state;
   logic         ERR;
`ifdef FIFO_READER_CNT_EN
   logic [15:0]  WCNT;
`endif

   int errors = 0;
   int checks = 0;
   int rd_cnt = 0;

   logic         s_rd, s_ov, s_err;
   logic [W-1:0] s_od;
   logic [1:0]   s_state;

   logic [W-1:0] fifo_q[$];
   logic [W-1:0] got_q[$];
   logic [W-1:0] exp_q[$];

   always #5 CLK = ~CLK;

   fifo_reader #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .RD(RD), .EMPTY(EMPTY), .FIFO_DOUT(FIFO_DOUT),
      .FIFO_VALID(FIFO_VALID), .UNDER(UNDER), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY), .o_dbg_state(o_dbg_state),
`ifdef FIFO_READER_CNT_EN
      .WCNT(WCNT),
`endif
      .ERR(ERR)
   );

   // One cycle: snapshot outputs mid-cycle, then answer the sampled RD one cycle later.
   task automatic tick();
      @(negedge CLK);
      s_rd = RD; s_ov = OUT_VALID; s_od = OUT_DATA; s_err = ERR; s_state = o_dbg_state;
      if (RD) rd_cnt++;
      if (OUT_VALID && OUT_READY) got_q.push_back(OUT_DATA);
      @(posedge CLK);
      #1;
      if (s_rd && (fifo_q.size() > 0)) begin
         FIFO_DOUT  = fifo_q.pop_front();
         FIFO_VALID = 1'b1;
      end else begin
         FIFO_VALID = 1'b0;
      end
      EMPTY = (fifo_q.size() == 0);
   endtask

   task automatic load(input logic [W-1:0] base, input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(base + W'(i));
      EMPTY = (fifo_q.size() == 0);
   endtask

   task automatic do_reset();
      RST = 1'b0; FIFO_VALID = 1'b0; UNDER = 1'b0; OUT_READY = 1'b0;
      fifo_q.delete(); EMPTY = 1'b1;
      tick(); tick();
      RST = 1'b1;
      got_q.delete(); rd_cnt = 0;
   endtask

   task automatic test_reset();
      #1 RST = 1'b0;
      EMPTY = 1'b1;
      tick();
      checks++; if (s_rd !== 1'b0)   begin errors++; $display("FAIL reset_rd: got %b want 0", s_rd); end
      checks++; if (s_ov !== 1'b0)   begin errors++; $display("FAIL reset_out_valid: got %b want 0", s_ov); end
      checks++; if (s_od !== 16'h0)  begin errors++; $display("FAIL reset_out_data: got %h want 0000", s_od); end
      checks++; if (s_err !== 1'b0)  begin errors++; $display("FAIL reset_err: got %b want 0", s_err); end
      tick();
      RST = 1'b1;
      tick();
      checks++; if (s_rd !== 1'b0)     begin errors++; $display("FAIL post_reset_rd: got %b want 0", s_rd); end
      checks++; if (s_ov !== 1'b0)     begin errors++; $display("FAIL post_reset_out_valid: got %b want 0", s_ov); end
      checks++; if (s_err !== 1'b0)    begin errors++; $display("FAIL post_reset_err: got %b want 0", s_err); end
      checks++; if (s_state !== 2'd0)  begin errors++; $display("FAIL post_reset_state: got %0d want 0", s_state); end
   endtask

   task automatic test_stream();
      got_q.delete(); rd_cnt = 0;
      OUT_READY = 1'b1;
      load(16'h0001, 8);
      for (int c = 0; c < 12; c++) begin
         tick();
         checks++;
         if (s_rd !== (c < 8)) begin errors++; $display("FAIL stream_rd[%0d]: got %b want %b", c, s_rd, (c < 8)); end
         checks++;
         if (s_ov !== (c >= 2 && c <= 9)) begin
            errors++; $display("FAIL stream_out_valid[%0d]: got %b want %b", c, s_ov, (c >= 2 && c <= 9));
         end
         if (c >= 2 && c <= 9) begin
            checks++;
            if (s_od !== W'(c - 1)) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", c, s_od, W'(c - 1)); end
         end
      end
      checks++; if (s_state !== 2'd0) begin errors++; $display("FAIL stream_end_state: got %0d want 0", s_state); end
      checks++; if (s_err !== 1'b0)   begin errors++; $display("FAIL stream_err: got %b want 0", s_err); end
   endtask

   task automatic test_backpressure();
      got_q.delete(); rd_cnt = 0;
      OUT_READY = 1'b0;
      load(16'h0011, 5);
      for (int c = 0; c < 6; c++) begin
         tick();
         if (c >= 2) begin
            checks++;
            if (s_od !== 16'h0011 || s_ov !== 1'b1) begin
               errors++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h want valid=1 data=0011", c, s_ov, s_od);
            end
         end
      end
      checks++; if (rd_cnt !== 2)     begin errors++; $display("FAIL bp_rd_pulses: got %0d want 2", rd_cnt); end
      checks++; if (s_state !== 2'd2) begin errors++; $display("FAIL bp_state_full: got %0d want 2", s_state); end
      OUT_READY = 1'b1;
      repeat (12) tick();
      exp_q.delete();
      for (int i = 0; i < 5; i++) exp_q.push_back(16'h0011 + W'(i));
      checks++; if (got_q.size() !== 5) begin errors++; $display("FAIL bp_count: got %0d want 5", got_q.size()); end
      for (int i = 0; i < 5 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (rd_cnt !== 5) begin errors++; $display("FAIL bp_total_rd: got %0d want 5", rd_cnt); end
   endtask

   task automatic test_toggle();
      got_q.delete(); rd_cnt = 0;
      OUT_READY = 1'b0;
      load(16'h0021, 8);
      for (int c = 0; c < 30; c++) begin
         OUT_READY = ~OUT_READY;
         tick();
      end
      OUT_READY = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(16'h0021 + W'(i));
      checks++; if (got_q.size() !== 8) begin errors++; $display("FAIL toggle_count: got %0d want 8", got_q.size()); end
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL toggle_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_error();
      do_reset();
      OUT_READY = 1'b0;
      load(16'h0031, 3);
      repeat (4) tick();
      checks++; if (rd_cnt !== 2) begin errors++; $display("FAIL err_setup_rd: got %0d want 2", rd_cnt); end
      FIFO_VALID = 1'b1;
      FIFO_DOUT  = 16'hDEAD;
      tick();
      checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL err_before_edge: got %b want 0", s_err); end
      tick();
      checks++; if (s_err !== 1'b1)   begin errors++; $display("FAIL err_set: got %b want 1", s_err); end
      checks++; if (s_state !== 2'd3) begin errors++; $display("FAIL err_state: got %0d want 3", s_state); end
      checks++; if (s_rd !== 1'b0)    begin errors++; $display("FAIL err_rd_blocked: got %b want 0", s_rd); end
      got_q.delete(); rd_cnt = 0;
      OUT_READY = 1'b1;
      repeat (6) tick();
      checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL err_drain_count: got %0d want 2", got_q.size()); end
      if (got_q.size() == 2) begin
         checks++;
         if (got_q[0] !== 16'h0031 || got_q[1] !== 16'h0032) begin
            errors++; $display("FAIL err_drain_data: got %h %h want 0031 0032", got_q[0], got_q[1]);
         end
      end
      checks++; if (rd_cnt !== 0)   begin errors++; $display("FAIL err_rd_stays_low: got %0d pulses want 0", rd_cnt); end
      checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", s_err); end
      RST = 1'b0;
      tick();
      checks++; if (s_err !== 1'b0)   begin errors++; $display("FAIL err_cleared: got %b want 0", s_err); end
      checks++; if (s_state !== 2'd0) begin errors++; $display("FAIL err_cleared_state: got %0d want 0", s_state); end
      do_reset();
   endtask

   task automatic test_reset_midop();
      do_reset();
      OUT_READY = 1'b0;
      load(16'h0041, 4);
      tick(); tick();
      RST = 1'b0;
      fifo_q.delete(); EMPTY = 1'b1;
      tick();
      checks++; if (s_ov !== 1'b0 || s_od !== 16'h0) begin
         errors++; $display("FAIL midop_discard: got valid=%b data=%h want 0 0000", s_ov, s_od);
      end
      checks++; if (s_rd !== 1'b0) begin errors++; $display("FAIL midop_rd: got %b want 0", s_rd); end
      RST = 1'b1;
      FIFO_VALID = 1'b1;
      FIFO_DOUT  = 16'h0042;
      tick();
      tick();
      checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL midop_stray_valid_err: got %b want 1", s_err); end
      checks++; if (s_ov !== 1'b0)  begin errors++; $display("FAIL midop_no_push: got %b want 0", s_ov); end
      do_reset();
   endtask

   task automatic test_under();
      do_reset();
      UNDER = 1'b1;
      tick();
      UNDER = 1'b0;
      tick();
      checks++; if (s_err !== 1'b1 || s_state !== 2'd3) begin
         errors++; $display("FAIL under_err: got err=%b state=%0d want 1 3", s_err, s_state);
      end
      do_reset();
      tick();
      checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL under_reset_clear: got %b want 0", s_err); end
   endtask

`ifdef FIFO_READER_CNT_EN
   task automatic test_wcnt();
      do_reset();
      checks++; if (WCNT !== 16'h0000) begin errors++; $display("FAIL wcnt_reset: got %h want 0000", WCNT); end
      OUT_READY = 1'b1;
      load(16'h0000, 65537);
      repeat (65537 + 6) tick();
      checks++; if (got_q.size() !== 65537) begin errors++; $display("FAIL wcnt_transfers: got %0d want 65537", got_q.size()); end
      checks++; if (WCNT !== 16'h0001) begin errors++; $display("FAIL wcnt_wrap: got %h want 0001", WCNT); end
      got_q.delete();
      do_reset();
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_toggle();
      test_error();
      test_reset_midop();
      test_under();
`ifdef FIFO_READER_CNT_EN
      test_wcnt();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
